// File: rtl/regfile_bypass_param_pkg.sv
// Shared constants and helpers for the decode-stage register file and the
// stages that talk to it.
package regfile_bypass_param_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 8;

    // Smallest select width that can address 'value' entries.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int DEF_ADDR_W = clog2(DEF_NUM_REGS);

    // Where a read port takes its data from in the current cycle.
    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_STORE,
        SRC_BYPASS
    } read_src_e;

endpackage

// File: rtl/regfile_bypass_param_if.sv
// Read/write bus between the decode stage and the register file.
interface regfile_bypass_param_if
    import regfile_bypass_param_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic [ADDR_W-1:0] read1RegSel;
    logic [ADDR_W-1:0] read2RegSel;
    logic [ADDR_W-1:0] writeRegSel;
    logic [DATA_W-1:0] writeData;
    logic              writeEn;
    logic [DATA_W-1:0] read1Data;
    logic [DATA_W-1:0] read2Data;
    logic              err;

    // Decode side: issues selects and write data, receives read data.
    modport master (
        output read1RegSel,
        output read2RegSel,
        output writeRegSel,
        output writeData,
        output writeEn,
        input  read1Data,
        input  read2Data,
        input  err
    );

    // Register file side.
    modport slave (
        input  read1RegSel,
        input  read2RegSel,
        input  writeRegSel,
        input  writeData,
        input  writeEn,
        output read1Data,
        output read2Data,
        output err
    );

endinterface

// File: rtl/regfile_bypass_param_reg_param.sv
// Storage cells: the basic clearable flop and a write-enabled register
// built on top of it.
module dff #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Plain flop with asynchronous active-high clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

module reg_param #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] next_q;

    // Recirculate the stored value unless this register is being written.
    always_comb begin
        next_q = en ? d : q;
    end

    dff #(.W(DATA_W)) u_dff (
        .clk (clk),
        .rst (rst),
        .d   (next_q),
        .q   (q)
    );

endmodule

// File: rtl/regfile_bypass_param.sv
// Decode-stage register file: two combinational read ports, one write port,
// optional same-cycle write forwarding, optional hard-wired zero register
// and a sticky flag for selects that point past the last register.
module regfile_bypass_param
    import regfile_bypass_param_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BYPASS_EN = 1,
    parameter int ZERO_REG  = 0
) (
    input logic                   clk,
    input logic                   rst,
    regfile_bypass_param_if.slave bus
);

    // One extra bit so NUM_REGS itself is representable for the range check.
    localparam logic [ADDR_W:0] REG_LIMIT  = (ADDR_W + 1)'(NUM_REGS);
    localparam bit              BYPASS_ON  = (BYPASS_EN != 0);
    localparam bit              ZERO_ON    = (ZERO_REG != 0);

    logic [DATA_W-1:0] reg_q [NUM_REGS];

    logic              sel1_ok;
    logic              sel2_ok;
    logic              wsel_ok;
    logic              write_ok;
    logic              write_fwd;
    logic              bypass1;
    logic              bypass2;
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;
    read_src_e         src1;
    read_src_e         src2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              err_q;
    logic              err_set;

    // Range checks on all three selects, and the qualified write strobe.
    always_comb begin
        sel1_ok  = ({1'b0, bus.read1RegSel} < REG_LIMIT);
        sel2_ok  = ({1'b0, bus.read2RegSel} < REG_LIMIT);
        wsel_ok  = ({1'b0, bus.writeRegSel} < REG_LIMIT);
        write_ok = bus.writeEn && wsel_ok;
    end

    // Register array; entry 0 becomes a constant when the zero register is on.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (ZERO_ON && (i == 0)) begin : g_zero
            assign reg_q[i] = '0;
        end else begin : g_store
            logic hit;
            assign hit = write_ok && (bus.writeRegSel == ADDR_W'(i));
            reg_param #(.DATA_W(DATA_W)) u_reg (
                .clk (clk),
                .rst (rst),
                .en  (hit),
                .d   (bus.writeData),
                .q   (reg_q[i])
            );
        end
    end

    // Stored-value muxes; a select with no matching register yields zero.
    always_comb begin
        stored1 = '0;
        stored2 = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (bus.read1RegSel == ADDR_W'(k)) begin
                stored1 = reg_q[k];
            end
            if (bus.read2RegSel == ADDR_W'(k)) begin
                stored2 = reg_q[k];
            end
        end
    end

    // Forwarding is only legal for a write that will actually land, and is
    // suppressed during reset so the ports read zero while rst is high.
    always_comb begin
        write_fwd = BYPASS_ON && !rst && write_ok &&
                    !(ZERO_ON && (bus.writeRegSel == '0));
        bypass1   = write_fwd && (bus.read1RegSel == bus.writeRegSel);
        bypass2   = write_fwd && (bus.read2RegSel == bus.writeRegSel);
    end

    // Pick the data source for each port independently.
    always_comb begin
        src1 = SRC_ZERO;
        src2 = SRC_ZERO;
        if (bypass1) begin
            src1 = SRC_BYPASS;
        end else if (sel1_ok) begin
            src1 = SRC_STORE;
        end
        if (bypass2) begin
            src2 = SRC_BYPASS;
        end else if (sel2_ok) begin
            src2 = SRC_STORE;
        end
    end

    // Drive the read data from the chosen source.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        case (src1)
            SRC_BYPASS: rd1 = bus.writeData;
            SRC_STORE:  rd1 = stored1;
            default:    rd1 = '0;
        endcase
        case (src2)
            SRC_BYPASS: rd2 = bus.writeData;
            SRC_STORE:  rd2 = stored2;
            default:    rd2 = '0;
        endcase
    end

    // Any out-of-range read select, or an enabled out-of-range write, trips err.
    always_comb begin
        err_set = !sel1_ok || !sel2_ok || (bus.writeEn && !wsel_ok);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign bus.read1Data = rd1;
    assign bus.read2Data = rd2;
    assign bus.err       = err_q;

endmodule

// File: doc/regfile_bypass_param.md
Name: regfile_bypass_param

Overview:
- Parametrised register file: NUM_REGS registers of DATA_W bits, two asynchronous read ports, one synchronous write port.
- Optional write-to-read bypass, so a read of the register being written in the same cycle returns the new data.
- Optional hard-wired zero register.
- Sits in the processor decode stage; replaces per-register hand-instantiated 16-bit registers.

Parameters:
- DATA_W, 16, width of each register and data port.
- NUM_REGS, 8, number of registers; 2..32, need not be a power of two.
- ADDR_W, 3, select width; must satisfy 2**ADDR_W >= NUM_REGS.
- BYPASS_EN, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value.
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- read1RegSel  input  ADDR_W  read port 1 select.
- read2RegSel  input  ADDR_W  read port 2 select.
- writeRegSel  input  ADDR_W  write select.
- writeData  input  DATA_W  write data.
- writeEn  input  1  write strobe.
- read1Data  output  DATA_W  read port 1 data (combinational).
- read2Data  output  DATA_W  read port 2 data (combinational).
- err  output  1  sticky illegal-access flag (registered).

Behaviour:
- Reset:
  - rst high clears every register to 0 and clears err, immediately and regardless of clk.
  - read1Data and read2Data therefore read 0 while rst is high.
  - Deassertion takes effect at the next rising edge.
- Write:
  - On a rising edge with writeEn=1 and writeRegSel < NUM_REGS, that register loads writeData.
  - All other registers hold their value.
  - Write latency is 1 cycle.
- Read: readNData is a combinational mux of the stored register selected by readNRegSel; latency 0.
- Bypass, BYPASS_EN=1:
  - Condition: writeEn=1, readNRegSel==writeRegSel, writeRegSel < NUM_REGS, and not (ZERO_REG=1 and writeRegSel==0).
  - Under that condition readNData=writeData in the same cycle.
  - Each read port evaluates bypass independently.
  - Both ports may bypass simultaneously.
- Bypass, BYPASS_EN=0: a same-cycle read returns the old value; the new value is visible the cycle after the edge.
- ZERO_REG=1: a write to register 0 is dropped; reads of register 0 return 0 and are never bypassed.
- Out-of-range select (value >= NUM_REGS):
  - A read returns 0.
  - A write is dropped; no register changes.
- err:
  - Set at the rising edge when either read select is >= NUM_REGS, or when writeEn=1 and writeRegSel >= NUM_REGS.
  - Stays 1 until rst.
  - A read select out of range sets err whether or not writeEn is asserted.
- Simultaneous write and reset: reset wins; the register stays 0.
- Reset mid-operation: all state cleared; the next write after rst deasserts behaves normally.
- All arithmetic is unsigned compare; no width truncation of data.

Decomposition:
- Shared package holds DATA_W and NUM_REGS default constants and the ADDR_W derivation (clog2 function) for decode and the other stages.
- Sub-module reg_param, DATA_W parameter:
  - Single register with write enable, built from the codebase dff cell.
  - Asynchronous active-high clear.
  - Instantiated NUM_REGS times (NUM_REGS-1 times when ZERO_REG=1).
- Read muxes, bypass compare and err flop live in the top module.

Test Plan:
- Reset clear: write 0xBEEF to regs 1..7, then pulse rst mid-cycle (asynchronous) → all reads return 0x0000 immediately, err=0.
- Write/read without overlap: write 0x1234 to r3; next cycle read1Sel=3, read2Sel=3 → both 0x1234; r2 unchanged at 0.
- Bypass on, same-cycle write to r5:
  - Setup: writeData=0xA5A5; r5 previously 0x0001.
  - read1Sel=5 → 0xA5A5; read2Sel=4 → old r4.
  - Repeat with BYPASS_EN=0 → read1 returns 0x0001 that cycle and 0xA5A5 the next.
- ZERO_REG=1: write 0xFFFF to r0 with read1Sel=0 in the same cycle → read1Data=0x0000 that cycle and after.
- Out of range with NUM_REGS=6, ADDR_W=3:
  - Write 0x7777 to sel 6 → no register changes, err=1 after the edge.
  - Read sel 7 → 0x0000.
  - err stays 1 through 10 legal cycles; clears only on rst.
- Simultaneous rst and writeEn to r2 with 0x5555 → r2 reads 0 after reset releases.
